// File: rtl/rom_load_arbiter_pkg.sv
// Shared types for the ROM download / read arbiter.
//   arb_state_t  : arbiter FSM states
//   fifo_entry_t : one queued download write {addr, data}
//   rr_grant1    : round-robin pick between the two read ports
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } arb_state_t;

    // The entry address field is sized for the widest supported memory;
    // narrower instances zero-extend on push and truncate on pop.
    localparam int unsigned ENTRY_AW = 24;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } fifo_entry_t;

    // Returns 1 when port 1 wins. With both pending, the port that did not
    // win last time is chosen.
    function automatic logic rr_grant1(input logic p0, input logic p1, input logic last);
        return p1 & (~p0 | ~last);
    endfunction

endpackage

// File: rtl/rom_load_arbiter_if.sv
// Read-request and memory bus bundle for rom_load_arbiter.
//   req0/req1, addr0/addr1 : read requests (held until ack)
//   ack0/ack1, rdata0/1    : one-cycle ack pulse, read data held until next ack
//   mem_addr/we/din        : memory port driven by the arbiter
//   mem_dout               : memory read data, valid one cycle after mem_addr
// slave  : arbiter side
// master : core side (requesters and memory)
interface rom_load_arbiter_if #(
    parameter int unsigned AW = 16
);
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          ack0;
    logic          ack1;
    logic [7:0]    rdata0;
    logic [7:0]    rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;

    modport slave (
        input  req0, req1, addr0, addr1, mem_dout,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_we, mem_din
    );

    modport master (
        output req0, req1, addr0, addr1, mem_dout,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/rom_load_arbiter_sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write request (ignored when full unless popping this cycle)
//   i_din    : write data
//   i_pop    : read request (ignored when empty)
//   o_dout   : head entry
//   o_count  : number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != (PW+1)'(DEPTH)) | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/rom_load_arbiter.sv
// Shares one single-port memory between the download write stream and two
// round-robin read requesters. Download writes are buffered and always win
// at IDLE; a read already issued runs to completion.
//   clk_sys, reset          : clock, asynchronous active-high reset
//   dn_download/wr/addr/data: download stream from data_io
//   bus (slave)             : read req/ack ports and memory port
//   overflow                : sticky, a write was dropped on a full FIFO
//   load_done               : pulse once the download ended and writes drained
module rom_load_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AW         = 16,
    parameter logic [24:0] ROM_BASE   = 25'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [24:0]       dn_addr,
    input  logic [7:0]        dn_data,
    rom_load_arbiter_if.slave bus,
    output logic              overflow,
    output logic              load_done
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    arb_state_t    r_state, w_next;
    logic [24:0]   w_off;
    logic          w_in_range, w_push, w_pop, w_empty, w_full, w_drop;
    logic [CW-1:0] w_count;
    fifo_entry_t   w_push_entry, w_head;
    logic          w_pend0, w_pend1, w_grant1, w_load_wr, w_load_rd;
    logic          r_last, r_sel, r_dl_q, r_armed, r_overflow;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [7:0]    r_mem_din;
    logic          r_ack0, r_ack1;
    logic [7:0]    r_rdata0, r_rdata1;

    // Window check on the offset also catches ROM_BASE+2^AW overflowing 25 bits.
    assign w_off      = dn_addr - ROM_BASE;
    assign w_in_range = (dn_addr >= ROM_BASE) && ((w_off >> AW) == '0);
    assign w_push     = dn_wr & w_in_range;

    always_comb begin
        w_push_entry.addr = ENTRY_AW'(w_off[AW-1:0]);
        w_push_entry.data = dn_data;
    end

    sync_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_sys),
        .rst    (reset),
        .i_push (w_push),
        .i_din  (w_push_entry),
        .i_pop  (w_pop),
        .o_dout (w_head),
        .o_count(w_count)
    );

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == CW'(FIFO_DEPTH));
    assign w_drop  = w_push & w_full & ~w_pop;

    // A request still high during its own ack cycle is the one just served.
    assign w_pend0  = bus.req0 & ~r_ack0;
    assign w_pend1  = bus.req1 & ~r_ack1;
    assign w_grant1 = rr_grant1(w_pend0, w_pend1, r_last);

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load_wr = 1'b0;
        w_load_rd = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next    = WRITE;
                    w_load_wr = 1'b1;
                end else if (w_pend0 | w_pend1) begin
                    w_next    = RD_ISSUE;
                    w_load_rd = 1'b1;
                end
            end
            WRITE: begin
                w_pop  = 1'b1;
                w_next = IDLE;
            end
            RD_ISSUE: w_next = RD_DATA;
            RD_DATA:  w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_dl_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            if (w_load_wr) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= AW'(w_head.addr);
                r_mem_din  <= w_head.data;
            end
            if (w_load_rd) begin
                r_mem_addr <= w_grant1 ? bus.addr1 : bus.addr0;
                r_sel      <= w_grant1;
                r_last     <= w_grant1;
            end
            if (r_state == RD_DATA) begin
                if (r_sel) begin
                    r_rdata1 <= bus.mem_dout;
                    r_ack1   <= 1'b1;
                end else begin
                    r_rdata0 <= bus.mem_dout;
                    r_ack0   <= 1'b1;
                end
            end
            r_dl_q <= dn_download;
            if (dn_download & ~r_dl_q)      r_armed <= 1'b0;
            else if (~dn_download & r_dl_q) r_armed <= 1'b1;
            else if (load_done)             r_armed <= 1'b0;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign load_done    = r_armed & w_empty & (r_state == IDLE);
    assign overflow     = r_overflow;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_din  = r_mem_din;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a synchronous RAM model.
`timescale 1ns/1ps
module tb_rom_load_arbiter;
    localparam int unsigned AW   = 16;
    localparam logic [24:0] BASE = 25'h10000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [24:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        overflow;
    logic        load_done;

    int n_checks = 0;
    int n_fail   = 0;

    rom_load_arbiter_if #(.AW(AW)) bus ();

    rom_load_arbiter #(.AW(AW), .ROM_BASE(BASE), .FIFO_DEPTH(4)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dn_download(dn_download),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .bus        (bus),
        .overflow   (overflow),
        .load_done  (load_done)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM: read data registered, old data on read-during-write.
    logic [7:0] mem [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = pat(AW'(i));
        bus.mem_dout = '0;
        forever begin
            @(posedge clk_sys);
            bus.mem_dout <= mem[bus.mem_addr];
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_din;
        end
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int            we_cnt = 0, we_last_cyc = 0, ack0_cnt = 0, ld_cnt = 0, ld_last_cyc = 0;
    logic [AW-1:0] we_last_addr = '0;
    logic [7:0]    we_last_din = '0;
    always @(negedge clk_sys) begin
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            we_last_cyc  = cyc;
            we_last_addr = bus.mem_addr;
            we_last_din  = bus.mem_din;
        end
        if (bus.ack0 === 1'b1) ack0_cnt++;
        if (load_done === 1'b1) begin
            ld_cnt++;
            ld_last_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        dn_wr = 1'b0;
        dn_download = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input bit port, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin n_fail++; $display("FAIL reset_mem: we=%b addr=%h din=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_din); end
        n_checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: ack0=%b ack1=%b want 0", bus.ack0, bus.ack1); end
        n_checks++; if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: %h %h want 0", bus.rdata0, bus.rdata1); end
        n_checks++; if (overflow !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags: ovf=%b done=%b want 0", overflow, load_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        do_reset();
        dn_wr = 1'b1; dn_addr = BASE + 25'd5; dn_data = 8'hA5;   // cycle n
        tick(); dn_wr = 1'b0;                                     // n+1
        tick();                                                   // n+2
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 16'h0005) begin n_fail++; $display("FAIL wr_addr: got %h want 0005", bus.mem_addr); end
        n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL wr_din: got %h want a5", bus.mem_din); end
        tick();                                                   // n+3, IDLE: grant
        bus.addr0 = 16'h0005; bus.req0 = 1'b1;
        tick();                                                   // n+4, RD_ISSUE
        n_checks++; if (bus.mem_addr !== 16'h0005 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_issue: addr=%h we=%b want 0005/0", bus.mem_addr, bus.mem_we); end
        tick();
        n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack: got %b want 0", bus.ack0); end
        tick();                                                   // n+6
        n_checks++; if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'hA5) begin n_fail++; $display("FAIL rd_ack: ack=%b data=%h want 1/a5", bus.ack0, bus.rdata0); end
        bus.req0 = 1'b0;
        tick();
        n_checks++; if (bus.ack0 !== 1'b0 || bus.rdata0 !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: ack=%b data=%h want 0/a5", bus.ack0, bus.rdata0); end
    endtask

    task automatic test_round_robin();
        logic [13:0] a0v, a1v;
        a0v = '0; a1v = '0;
        bus.addr0 = 16'h0010; bus.addr1 = 16'h0020;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;                                             // cycle r
        for (int i = 1; i <= 13; i++) begin
            tick();
            a0v[i] = bus.ack0;
            a1v[i] = bus.ack1;
        end
        n_checks++; if (a0v !== 14'h0208) begin n_fail++; $display("FAIL rr_ack0: got %b want %b", a0v, 14'h0208); end
        n_checks++; if (a1v !== 14'h1040) begin n_fail++; $display("FAIL rr_ack1: got %b want %b", a1v, 14'h1040); end
        n_checks++; if (bus.rdata0 !== pat(16'h0010) || bus.rdata1 !== pat(16'h0020)) begin n_fail++; $display("FAIL rr_data: got %h %h want %h %h", bus.rdata0, bus.rdata1, pat(16'h0010), pat(16'h0020)); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_priority();
        int lat, we0;
        do_reset();
        bus.addr1 = 16'h0040; bus.req1 = 1'b1;
        wait_ack(1'b1, lat);
        bus.req1 = 1'b0;
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL plain_lat: got %0d want 3", lat); end
        tick(); tick();
        we0 = we_cnt;
        dn_wr = 1'b1; dn_addr = BASE + 25'h30; dn_data = 8'h3C;  // cycle n
        tick(); dn_wr = 1'b0;                                     // n+1: FIFO non-empty
        bus.req1 = 1'b1;
        wait_ack(1'b1, lat);
        bus.req1 = 1'b0;
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL prio_lat: got %0d want 5", lat); end
        n_checks++; if (we_cnt - we0 != 1 || we_last_addr !== 16'h0030 || we_last_cyc != cyc - 4) begin n_fail++; $display("FAIL prio_write: n=%0d addr=%h at %0d want 1/0030/%0d", we_cnt - we0, we_last_addr, we_last_cyc, cyc - 4); end
        n_checks++; if (bus.rdata1 !== pat(16'h0040)) begin n_fail++; $display("FAIL prio_data: got %h want %h", bus.rdata1, pat(16'h0040)); end
    endtask

    task automatic test_range();
        int we0;
        do_reset();
        we0 = we_cnt;
        dn_wr = 1'b1; dn_addr = BASE + 25'h10000; dn_data = 8'h11;
        tick(); dn_wr = 1'b0; tick();
        dn_wr = 1'b1; dn_addr = BASE - 25'd1; dn_data = 8'h22;
        tick(); dn_wr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (we_cnt - we0 != 0) begin n_fail++; $display("FAIL range_out: writes=%0d want 0", we_cnt - we0); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL range_ovf: got %b want 0", overflow); end
        dn_wr = 1'b1; dn_addr = BASE; dn_data = 8'h66;
        tick(); dn_wr = 1'b0; tick(); tick(); tick();
        n_checks++; if (we_cnt - we0 != 1 || we_last_addr !== 16'h0000 || we_last_din !== 8'h66) begin n_fail++; $display("FAIL range_lo: n=%0d addr=%h din=%h want 1/0000/66", we_cnt - we0, we_last_addr, we_last_din); end
        dn_wr = 1'b1; dn_addr = BASE + 25'hFFFF; dn_data = 8'h77;
        tick(); dn_wr = 1'b0; tick(); tick(); tick();
        n_checks++; if (we_cnt - we0 != 2 || we_last_addr !== 16'hFFFF || we_last_din !== 8'h77) begin n_fail++; $display("FAIL range_hi: n=%0d addr=%h din=%h want 2/ffff/77", we_cnt - we0, we_last_addr, we_last_din); end
    endtask

    task automatic test_overflow();
        int we0;
        do_reset();
        we0 = we_cnt;
        for (int k = 0; k < 8; k++) begin
            dn_wr = 1'b1; dn_addr = BASE + 25'h100 + 25'(k); dn_data = 8'h80 + 8'(k);
            if (k == 7) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
            tick();
        end
        dn_wr = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (we_cnt - we0 != 7 || we_last_addr !== 16'h0106 || we_last_din !== 8'h86) begin n_fail++; $display("FAIL ovf_drain: n=%0d addr=%h din=%h want 7/0106/86", we_cnt - we0, we_last_addr, we_last_din); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        do_reset();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_load_done();
        int we0, ld0, m;
        do_reset();
        we0 = we_cnt; ld0 = ld_cnt;
        dn_download = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dn_wr = 1'b1; dn_addr = BASE + 25'h200 + 25'(k); dn_data = 8'h90 + 8'(k);
            tick();
        end
        dn_wr = 1'b0; dn_download = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_checks++; if (we_cnt - we0 != 3 || ld_cnt - ld0 != 1) begin n_fail++; $display("FAIL ld_count: writes=%0d pulses=%0d want 3/1", we_cnt - we0, ld_cnt - ld0); end
        n_checks++; if (ld_last_cyc != we_last_cyc + 1) begin n_fail++; $display("FAIL ld_timing: pulse at %0d want %0d", ld_last_cyc, we_last_cyc + 1); end
        // fall then rise while writes are still queued: no pulse
        ld0 = ld_cnt;
        dn_download = 1'b1;
        dn_wr = 1'b1; dn_addr = BASE + 25'h300; dn_data = 8'hB0; tick();
        dn_addr = BASE + 25'h301; dn_data = 8'hB1; tick();
        dn_wr = 1'b0; dn_download = 1'b0; tick();
        dn_download = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (ld_cnt - ld0 != 0) begin n_fail++; $display("FAIL ld_cancel: pulses=%0d want 0", ld_cnt - ld0); end
        dn_download = 1'b0; m = cyc;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (ld_cnt - ld0 != 1 || ld_last_cyc != m + 1) begin n_fail++; $display("FAIL ld_empty: pulses=%0d at %0d want 1 at %0d", ld_cnt - ld0, ld_last_cyc, m + 1); end
    endtask

    task automatic test_reset_mid_read();
        int lat, a0;
        do_reset();
        bus.addr0 = 16'h0010; bus.req0 = 1'b1;
        wait_ack(1'b0, lat);
        bus.req0 = 1'b0;
        n_checks++; if (lat != 3 || bus.rdata0 !== pat(16'h0010)) begin n_fail++; $display("FAIL mid_pre: lat=%0d data=%h want 3/%h", lat, bus.rdata0, pat(16'h0010)); end
        tick();
        a0 = ack0_cnt;
        bus.addr0 = 16'h0123; bus.req0 = 1'b1;                    // cycle c, IDLE
        tick();                                                   // c+1, RD_ISSUE
        n_checks++; if (bus.mem_addr !== 16'h0123) begin n_fail++; $display("FAIL mid_issue: addr=%h want 0123", bus.mem_addr); end
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_we, bus.mem_din, overflow, load_done} !== '0) begin n_fail++; $display("FAIL mid_zero: rd0=%h addr=%h din=%h want 0", bus.rdata0, bus.mem_addr, bus.mem_din); end
        bus.req0 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (ack0_cnt - a0 != 0) begin n_fail++; $display("FAIL mid_noack: acks=%0d want 0", ack0_cnt - a0); end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_priority();
        test_range();
        test_overflow();
        test_load_done();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
